mult_div_unit: RTL and testbench

//  E-stage multiply/divide unit with HI/LO. Executes mult/multu/div/divu over a fixed

---
 rtl/mult_div_unit_pkg.sv | 36 +++
 rtl/mult_div_unit.sv | 119 +++++++++++
 tb/tb_mult_div_unit.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared opcodes, widths and types for the E-stage multiply/divide unit.
package mult_div_unit_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned MD_OP_W = 4;

  localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd0;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd1;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd2;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd3;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd4;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd5;
  localparam logic [MD_OP_W-1:0] MD_MFHI  = 4'd6;
  localparam logic [MD_OP_W-1:0] MD_MFLO  = 4'd7;
  localparam logic [MD_OP_W-1:0] MD_NONE  = 4'd15;

  localparam int unsigned MD_MULT_CYCLES = 5;
  localparam int unsigned MD_DIV_CYCLES  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } md_result_t;

  // True for the opcodes that occupy the unit for several cycles.
  function automatic logic is_md_arith(input logic [MD_OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit: result computed at Start, committed to HI/LO
// after a fixed modelled latency; mt/mf moves complete in one cycle.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Start,
  input  logic [MD_OP_W-1:0] MDOp,
  input  logic [XLEN-1:0]    A,
  input  logic [XLEN-1:0]    B,
  input  logic               Req,
  output logic               Busy,
  output logic [XLEN-1:0]    HI,
  output logic [XLEN-1:0]    LO,
  output logic [XLEN-1:0]    MDOut
);

  md_state_e         state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic [XLEN-1:0]   hi_q;
  logic [XLEN-1:0]   lo_q;
  md_result_t        tmp_q;
  md_result_t        res_d;

  logic signed [2*XLEN-1:0] a_sx, b_sx, prod_s;
  logic [2*XLEN-1:0]        prod_u;
  logic [XLEN-1:0]          a_mag, b_mag, q_mag, r_mag, quo_s, rem_s;
  logic [XLEN-1:0]          quo_u, rem_u;

  assign a_sx   = {{XLEN{A[XLEN-1]}}, A};
  assign b_sx   = {{XLEN{B[XLEN-1]}}, B};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {{XLEN{1'b0}}, A} * {{XLEN{1'b0}}, B};

  // Signed divide on magnitudes so 0x80000000 / -1 wraps without a trap.
  assign a_mag = A[XLEN-1] ? (~A + XLEN'(1)) : A;
  assign b_mag = B[XLEN-1] ? (~B + XLEN'(1)) : B;
  assign q_mag = a_mag / b_mag;
  assign r_mag = a_mag % b_mag;
  assign quo_s = (A[XLEN-1] ^ B[XLEN-1]) ? (~q_mag + XLEN'(1)) : q_mag;
  assign rem_s = A[XLEN-1] ? (~r_mag + XLEN'(1)) : r_mag;
  assign quo_u = A / B;
  assign rem_u = A % B;

  // Divide by zero latches the current HI/LO so the commit leaves them unchanged.
  always_comb begin
    res_d = '{hi: hi_q, lo: lo_q};
    case (MDOp)
      MD_MULT:  res_d = md_result_t'(prod_s);
      MD_MULTU: res_d = md_result_t'(prod_u);
      MD_DIV:   if (B != '0) res_d = '{hi: rem_s, lo: quo_s};
      MD_DIVU:  if (B != '0) res_d = '{hi: rem_u, lo: quo_u};
      default:  res_d = '{hi: hi_q, lo: lo_q};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      tmp_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Start && !Req && is_md_arith(MDOp)) begin
            state_q <= ST_BUSY;
            busy_q  <= 1'b1;
            tmp_q   <= res_d;
            cnt_q   <= ((MDOp == MD_DIV) || (MDOp == MD_DIVU)) ? CNT_W'(DIV_CYCLES)
                                                                : CNT_W'(MULT_CYCLES);
          end else if (!Req && (MDOp == MD_MTHI)) begin
            hi_q <= A;
          end else if (!Req && (MDOp == MD_MTLO)) begin
            lo_q <= A;
          end
        end
        ST_BUSY: begin
          // Requests and new starts are ignored until the in-flight op commits.
          if (cnt_q == CNT_W'(1)) begin
            hi_q    <= tmp_q.hi;
            lo_q    <= tmp_q.lo;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    MDOut = '0;
    case (MDOp)
      MD_MFHI: MDOut = hi_q;
      MD_MFLO: MDOut = lo_q;
      default: MDOut = '0;
    endcase
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus queues expected per-cycle
// observations from an arithmetic reference model; a monitor checks them.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int unsigned N_MULT = 5;
  localparam int unsigned N_DIV  = 10;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [3:0]  MDOp;
  logic [31:0] A, B;
  logic        Req;
  logic        Busy;
  logic [31:0] HI, LO, MDOut;

  mult_div_unit #(.MULT_CYCLES(N_MULT), .DIV_CYCLES(N_DIV)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp), .A(A), .B(B),
    .Req(Req), .Busy(Busy), .HI(HI), .LO(LO), .MDOut(MDOut)
  );

  typedef struct {
    int          cyc;
    bit          busy;
    logic [31:0] hi;
    logic [31:0] lo;
    bit          md_chk;
    logic [31:0] md;
  } exp_t;

  exp_t        sb_q[$];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp_v);
    end
  endfunction

  // Reference model: results from plain integer arithmetic.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                inout logic [31:0] hi, inout logic [31:0] lo);
    int ai, bi;
    longint sa, sb, p, qm, q, r;
    longint unsigned pu;
    ai = a; bi = b; sa = ai; sb = bi;
    case (op)
      MD_MULT:  begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      MD_MULTU: begin pu = {32'b0, a} * {32'b0, b}; hi = pu[63:32]; lo = pu[31:0]; end
      MD_DIV: if (b != 0) begin
        qm = (sa < 0 ? -sa : sa) / (sb < 0 ? -sb : sb);
        q  = ((sa < 0) != (sb < 0)) ? -qm : qm;
        r  = sa - q * sb;
        lo = q[31:0]; hi = r[31:0];
      end
      MD_DIVU: if (b != 0) begin lo = a / b; hi = a % b; end
      MD_MTHI: hi = a;
      MD_MTLO: lo = a;
      default: ;
    endcase
  endfunction

  function automatic void push(input int c, input bit bz, input bit mc, input logic [31:0] md);
    exp_t e;
    e.cyc = c; e.busy = bz; e.hi = m_hi; e.lo = m_lo; e.md_chk = mc; e.md = md;
    sb_q.push_back(e);
  endfunction

  // Monitor: compare the DUT at the negedge of each cycle an entry is due.
  always @(negedge clk) begin
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
      e = sb_q.pop_front();
      total++; bad++;
      $display("FAIL missed_check: got none expected check at cyc %0d", e.cyc);
    end
    while (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
      e = sb_q.pop_front();
      chk("busy", {31'b0, Busy}, {31'b0, e.busy});
      chk("hi", HI, e.hi);
      chk("lo", LO, e.lo);
      if (e.md_chk) chk("mdout", MDOut, e.md);
    end
  end

  always @(posedge clk) begin
    if (reset === 1'b1 && Busy === 1'b1 && Start === 1'b1) begin
      bad++;
      $display("FAIL start_while_busy: got Start=1 expected 0 while Busy");
    end
  end

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit req);
    int t, n;
    bit arith;
    arith = is_md_arith(op);
    n = ((op == MD_DIV) || (op == MD_DIVU)) ? N_DIV : N_MULT;
    @(posedge clk); #1;
    Start = arith; MDOp = op; A = a; B = b; Req = req;
    t = cyc;
    if (arith && !req) begin
      push(t + 1, 1'b1, 1'b0, '0);
      push(t + n, 1'b1, 1'b0, '0);
      model(op, a, b, m_hi, m_lo);
      push(t + n + 1, 1'b0, 1'b0, '0);
    end else begin
      if (!req) model(op, a, b, m_hi, m_lo);
      push(t + 1, 1'b0, 1'b0, '0);
      push(t + 2, 1'b0, 1'b0, '0);
    end
    @(posedge clk); #1;
    Start = 1'b0; MDOp = MD_NONE; Req = 1'b0;
    if (arith && !req) repeat (n) @(posedge clk);
    else @(posedge clk);
  endtask

  task automatic do_mf(input logic [3:0] op);
    logic [31:0] md;
    md = (op == MD_MFHI) ? m_hi : (op == MD_MFLO) ? m_lo : 32'h0;
    @(posedge clk); #1;
    MDOp = op; A = $urandom; B = $urandom;
    push(cyc, 1'b0, 1'b1, md);
    @(posedge clk); #1;
    MDOp = MD_NONE;
  endtask

  logic [31:0] corner [8];

  initial begin
    int t;
    logic [3:0] ops [6];
    logic [3:0] op;
    logic [31:0] a, b;
    corner[0] = 32'h0;        corner[1] = 32'h1;        corner[2] = 32'hFFFF_FFFF;
    corner[3] = 32'h8000_0000; corner[4] = 32'h7FFF_FFFF; corner[5] = 32'h2;
    corner[6] = 32'hFFFF_FFFE; corner[7] = 32'h0001_0000;
    ops[0] = MD_MULT; ops[1] = MD_MULTU; ops[2] = MD_DIV;
    ops[3] = MD_DIVU; ops[4] = MD_MTHI;  ops[5] = MD_MTLO;

    reset = 1'b0; Start = 1'b0; MDOp = MD_NONE; A = '0; B = '0; Req = 1'b0;
    repeat (3) @(posedge clk); #1;
    push(cyc, 1'b0, 1'b0, '0);
    @(posedge clk); #1;
    reset = 1'b1;

    do_op(MD_MULT,  32'hFFFF_FFFE, 32'd3, 1'b0);
    do_mf(MD_MFHI);
    do_op(MD_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0);
    do_mf(MD_MFLO);
    do_op(MD_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0);
    do_op(MD_DIVU,  32'd7,         32'd2, 1'b0);
    do_op(MD_MTHI,  32'h11, 32'h0, 1'b0);
    do_op(MD_MTLO,  32'h22, 32'h0, 1'b0);
    do_op(MD_DIV,   32'h1234, 32'h0, 1'b0);
    do_op(MD_MTLO,  32'h1234, 32'h0, 1'b0);
    do_op(MD_MTLO,  32'h5678, 32'h0, 1'b1);
    do_op(MD_MULT,  32'h7, 32'h9, 1'b1);
    do_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_mf(MD_MFHI);
    do_mf(MD_MULT);

    // Reset three cycles into a divide aborts it.
    @(posedge clk); #1;
    Start = 1'b1; MDOp = MD_DIV; A = 32'd100; B = 32'd7; Req = 1'b0;
    t = cyc;
    push(t + 1, 1'b1, 1'b0, '0);
    @(posedge clk); #1;
    Start = 1'b0; MDOp = MD_NONE;
    repeat (2) @(posedge clk); #1;
    push(t + 3, 1'b1, 1'b0, '0);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    push(t + 4, 1'b0, 1'b0, '0);
    @(posedge clk); #1;
    reset = 1'b1;
    do_mf(MD_MFLO);

    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(5)];
      a = ($urandom_range(3) == 0) ? corner[$urandom_range(7)] : $urandom;
      b = ($urandom_range(3) == 0) ? corner[$urandom_range(7)] : $urandom;
      if ($urandom_range(7) == 0) b = '0;
      do_op(op, a, b, $urandom_range(7) == 0);
      do_mf((i % 2 == 0) ? MD_MFHI : MD_MFLO);
    end

    for (int i = 0; i < 50 && sb_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    if (sb_q.size() > 0) begin
      total++; bad++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
